rp_frame_sequencer: RTL and testbench

Frame-level controller for the `repeated_pattern` mask generator. It latches a pattern configuration from the micro-processor, then sequences the generator row by row: reset, load, then stream `IMG_W` mask bits per row for `IMG_H` rows. It gates the generator's clock enable so the mask stream honours a valid/ready handshake toward the downstream mask consumer, and it flags row and frame boundaries.

---
 rtl/rp_frame_sequencer.sv | 156 +++++++++++++++
 tb/tb_rp_frame_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rp_frame_sequencer.sv
// Frame-level controller for the repeated_pattern mask generator: latches a pattern, then runs
// reset/load/stream per row with valid/ready gating. Define RP_ROW_ROTATE_EN for per-row rotation.
module rp_frame_sequencer #(
  parameter int IMG_W = 300,
  parameter int IMG_H = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic [4:0]  cfg_pattern_w,
  input  logic [0:31] cfg_pattern,
  output logic        busy,
  output logic        cfg_err,
  output logic        frame_done,
  output logic        rp_rst_n,
  output logic        rp_clk_en,
  output logic        rp_load_pattern,
  output logic [4:0]  rp_pattern_w,
  output logic [0:31] rp_pattern,
  input  logic        rp_mask_bit,
  input  logic        rp_valid,
  output logic        m_bit,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last_col,
  output logic        m_last_row
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [4:0]    pat_w_q, pat_w_d;
  logic [0:31]   pat_q, pat_d;
  logic          rp_rst_n_q;
  logic          cfg_err_q, cfg_err_d;
  logic          xfer_s;

  // One-phase rotation inside the active width; bits at or above w are left untouched.
  function automatic logic [0:31] rotate_pattern(input logic [0:31] p, input logic [4:0] w);
    logic [0:31] r;
    r = p;
    for (int i = 1; i < 32; i++) begin
      if (i < int'(w)) r[i] = p[i-1];
      else             r[i] = p[i];
    end
    r[0] = p[w - 5'd1];
    return r;
  endfunction

  assign xfer_s = m_valid & m_ready;

  // State, counter and latched-configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= {CW{1'b0}};
      row_q      <= {RW{1'b0}};
      pat_w_q    <= 5'd0;
      pat_q      <= 32'd0;
      rp_rst_n_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pat_w_q    <= pat_w_d;
      pat_q      <= pat_d;
      rp_rst_n_q <= (state_d != S_RST);
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next-state and counter logic; everything holds while clk_en is low.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    pat_w_d   = pat_w_q;
    pat_d     = pat_q;
    cfg_err_d = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (start && (cfg_pattern_w != 5'd0)) begin
            pat_w_d = cfg_pattern_w;
            pat_d   = cfg_pattern;
            col_d   = {CW{1'b0}};
            row_d   = {RW{1'b0}};
            state_d = S_RST;
          end else begin
            cfg_err_d = start;
          end
        end
        S_RST:  state_d = S_LOAD;
        S_LOAD: state_d = S_STREAM;
        S_STREAM: begin
          if (xfer_s && (col_q == COL_LAST)) begin
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + RW'(1);
              col_d   = {CW{1'b0}};
              state_d = S_RST;
`ifdef RP_ROW_ROTATE_EN
              pat_d   = rotate_pattern(pat_q, pat_w_q);
`else
              pat_d   = pat_q;
`endif
            end
          end else if (xfer_s) begin
            col_d = col_q + CW'(1);
          end else begin
            col_d = col_q;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode; generator enable is stalled by back-pressure and by clk_en.
  always_comb begin
    busy            = (state_q != S_IDLE);
    frame_done      = (state_q == S_DONE);
    rp_load_pattern = (state_q == S_LOAD);
    m_valid         = (state_q == S_STREAM) & rp_valid;
    rp_clk_en       = clk_en & ((state_q == S_LOAD) |
                                ((state_q == S_STREAM) & (~rp_valid | m_ready)));
  end

  assign cfg_err      = cfg_err_q;
  assign rp_rst_n     = rp_rst_n_q;
  assign rp_pattern_w = pat_w_q;
  assign rp_pattern   = pat_q;
  assign m_bit        = rp_mask_bit;
  assign m_last_col   = (col_q == COL_LAST);
  assign m_last_row   = (row_q == ROW_LAST);

endmodule

// File: tb/tb_rp_frame_sequencer.sv
// Self-checking bench for rp_frame_sequencer with a behavioural repeated_pattern generator.
module tb_rp_frame_sequencer;
  localparam int W = 8;
  localparam int H = 3;
`ifdef RP_ROW_ROTATE_EN
  localparam logic [23:0] ROWS_1011 = 24'b11011101_10111011_01110111;
`else
  localparam logic [23:0] ROWS_1011 = 24'b11011101_11011101_11011101;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cfg_pattern_w = 5'd0;
  logic [0:31] cfg_pattern = 32'd0;
  logic        busy, cfg_err, frame_done, rp_rst_n, rp_clk_en, rp_load_pattern;
  logic [4:0]  rp_pattern_w;
  logic [0:31] rp_pattern;
  logic        rp_mask_bit, rp_valid, m_bit, m_valid, m_last_col, m_last_row;
  logic        m_ready = 1'b1;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  rp_frame_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
    .cfg_pattern_w(cfg_pattern_w), .cfg_pattern(cfg_pattern),
    .busy(busy), .cfg_err(cfg_err), .frame_done(frame_done),
    .rp_rst_n(rp_rst_n), .rp_clk_en(rp_clk_en), .rp_load_pattern(rp_load_pattern),
    .rp_pattern_w(rp_pattern_w), .rp_pattern(rp_pattern),
    .rp_mask_bit(rp_mask_bit), .rp_valid(rp_valid),
    .m_bit(m_bit), .m_valid(m_valid), .m_ready(m_ready),
    .m_last_col(m_last_col), .m_last_row(m_last_row)
  );

  // Generator stand-in: emits pattern[w-1] down to pattern[0] repeatedly, one bit per enable.
  logic [0:31] g_pat;
  logic [4:0]  g_w, g_idx;
  always @(posedge clk or negedge rp_rst_n) begin
    if (!rp_rst_n) begin
      g_pat <= 32'd0; g_w <= 5'd1; g_idx <= 5'd0; rp_valid <= 1'b0; rp_mask_bit <= 1'b0;
    end else if (rp_clk_en) begin
      if (rp_load_pattern) begin
        g_pat <= rp_pattern; g_w <= rp_pattern_w; g_idx <= rp_pattern_w - 5'd1; rp_valid <= 1'b0;
      end else begin
        rp_mask_bit <= g_pat[g_idx];
        rp_valid    <= 1'b1;
        g_idx       <= (g_idx == 5'd0) ? g_w - 5'd1 : g_idx - 5'd1;
      end
    end
  end

  typedef struct {
    logic [4:0]  w;
    logic [0:31] pat;
    bit          rnd;
    int          drop_at;
    int          abort_at;
    bit          use_tbl;
    logic [23:0] rows;
    int          exp_n;
  } vec_t;

  vec_t tv[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Row r streams the pattern rotated r phases, each pattern read from index w-1 downwards.
  function automatic logic exp_bit(input logic [0:31] p, input int w, input int row, input int col);
    int r, idx, src;
`ifdef RP_ROW_ROTATE_EN
    r = row;
`else
    r = 0;
`endif
    idx = w - 1 - (col % w);
    src = (((idx - r) % w) + w) % w;
    return p[src];
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " rp_rst_n"}, rp_rst_n, 0);
    check({tag, " rp_load_pattern"}, rp_load_pattern, 0);
    check({tag, " rp_clk_en"}, rp_clk_en, 0);
    check({tag, " m_valid"}, m_valid, 0);
    check({tag, " rp_pattern_w"}, rp_pattern_w, 0);
    check({tag, " rp_pattern"}, rp_pattern, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int n, cyc, last_cyc, drop_left, poke_at, row, col;
    bit fin, stalled;
    logic held_bit, held_lc, eb;
    n = 0; cyc = 0; last_cyc = 0; drop_left = 0; fin = 1'b0; stalled = 1'b0;
    held_bit = 1'b0; held_lc = 1'b0;
    poke_at = (v.drop_at >= 0) ? v.drop_at + 4 : -1;
    cfg_pattern_w = v.w; cfg_pattern = v.pat; clk_en = 1'b1; m_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (!fin) begin
      clk_en = (drop_left > 0) ? 1'b0 : 1'b1;
      if (drop_left > 0) drop_left--;
      m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke_at >= 0 && n == poke_at) ? 1'b1 : 1'b0;
      if (start) cfg_pattern_w = 5'd7;
      @(negedge clk);
      if (cyc == 1) begin
        check("rst phase rp_rst_n", rp_rst_n, 0);
        check("rst phase busy", busy, 1);
      end
      if (cyc == 2) begin
        check("load rp_load_pattern", rp_load_pattern, 1);
        check("load rp_clk_en", rp_clk_en, 1);
        check("load rp_pattern_w", rp_pattern_w, v.w);
        check("load rp_pattern", rp_pattern, v.pat);
      end
      if (start) check("start in stream ignored", rp_pattern_w, v.w);
      if (stalled) begin
        check("stall m_valid", m_valid, 1);
        check("stall m_bit", m_bit, held_bit);
        check("stall m_last_col", m_last_col, held_lc);
      end
      stalled = m_valid && !(m_ready && clk_en);
      if (stalled) begin
        held_bit = m_bit; held_lc = m_last_col;
        check("stall rp_clk_en", rp_clk_en, 0);
      end
      if (m_valid && m_ready && clk_en) begin
        if (n < W * H) begin
          row = n / W; col = n % W;
          eb = v.use_tbl ? v.rows[23 - n] : exp_bit(v.pat, int'(v.w), row, col);
          check("m_bit", m_bit, eb);
          check("m_last_col", m_last_col, 32'(col == W - 1));
          check("m_last_row", m_last_row, 32'(row == H - 1));
          if (!v.rnd && v.drop_at < 0) begin
            if (n == 0)        check("first valid latency", cyc, 4);
            else if (col == 0) check("row gap", cyc - last_cyc, 4);
            else               check("back to back", cyc - last_cyc, 1);
          end
        end else begin
          check("extra transfer index", n, W * H - 1);
        end
        last_cyc = cyc; n++;
        if (n == v.drop_at) drop_left = 5;
        if (n == v.abort_at) begin
          rst_n = 1'b0;
          #1;
          check_reset_outputs("abort");
          @(posedge clk); #1;
          @(posedge clk); #1;
          rst_n = 1'b1;
          @(posedge clk); #1;
          check("abort rp_rst_n release", rp_rst_n, 1);
          check("abort busy after release", busy, 0);
          fin = 1'b1;
        end
      end
      if (frame_done) begin
        check("frame_done transfer count", n, W * H);
        check("frame_done timing", cyc - last_cyc, 1);
        fin = 1'b1;
      end
      if (cyc > 600) begin
        check("frame timeout cycles", cyc, 600);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    clk_en = 1'b1; start = 1'b0;
    if (v.abort_at < 0) begin
      @(posedge clk); #1;
      check("post frame busy", busy, 0);
      check("post frame frame_done", frame_done, 0);
    end
    check("transfer count", n, v.exp_n);
  endtask

  initial begin
    for (int i = 0; i < 10; i++) begin
      tv[i].w = 5'd4; tv[i].pat = 32'hB000_0000; tv[i].rnd = 1'b0;
      tv[i].drop_at = -1; tv[i].abort_at = -1; tv[i].use_tbl = 1'b1;
      tv[i].rows = ROWS_1011; tv[i].exp_n = W * H;
    end
    tv[1].rnd = 1'b1;
    tv[2].drop_at = 3;
    tv[3].abort_at = 10; tv[3].exp_n = 10;
    tv[5].w = 5'd1;  tv[5].pat = $urandom; tv[5].use_tbl = 1'b0;
    tv[6].w = 5'd31; tv[6].pat = $urandom; tv[6].use_tbl = 1'b0; tv[6].rnd = 1'b1;
    tv[7].w = 5'($urandom_range(2, 30)); tv[7].pat = $urandom; tv[7].use_tbl = 1'b0;
    tv[8].w = 5'($urandom_range(1, 31)); tv[8].pat = $urandom; tv[8].use_tbl = 1'b0; tv[8].rnd = 1'b1;
    tv[9].w = 5'd3;  tv[9].pat = $urandom; tv[9].use_tbl = 1'b0; tv[9].drop_at = 12;

    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rp_rst_n after release", rp_rst_n, 1);
    check("busy after release", busy, 0);

    cfg_pattern_w = 5'd0; cfg_pattern = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_err pulse", cfg_err, 1);
    check("cfg_err busy", busy, 0);
    check("cfg_err rp_rst_n", rp_rst_n, 1);
    @(posedge clk); #1;
    check("cfg_err one cycle", cfg_err, 0);
    check("cfg_err busy later", busy, 0);
    check("cfg_err no load", rp_load_pattern, 0);
    check("cfg_err no clk_en", rp_clk_en, 0);
    check("cfg_err width not latched", rp_pattern_w, 0);

    for (int i = 0; i < 10; i++) begin
      run_frame(tv[i]);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
